// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-cathode/anode display.
// Each digit gets a slot of SCAN_DIV clock cycles. The first GUARD cycles of
// every slot are blanked so the segment lines can settle before the next
// digit is enabled (no ghosting). New 4-digit values are taken in through a
// valid/ready handshake into a shadow register and only copied to the
// visible register at a frame boundary, so a frame never shows a mix of old
// and new digits.
//
// Parameters:
//   SCAN_DIV : cycles per digit slot (4 .. 2^24-1)
//   GUARD    : blanked cycles at the start of each slot (must be < SCAN_DIV)
//
// Ports:
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high reset
//   wr_valid    : a new 4-digit value is offered on wr_data
//   wr_data     : four 4-bit codes, [3:0] is digit 0 (rightmost)
//   wr_ready    : high when the shadow register is free to take a value
//   hold        : freezes the scan position (write path keeps running)
//   digit_en    : one-hot digit enable, all zero while blanked
//   digit_val   : code of the currently scanned digit for the seg7 decoder
//   frame_start : high during the first cycle of digit 0's slot
//
// Optional build macro:
//   DISPLAY_SCAN_LEADING_ZERO_BLANK_EN : blanks leading zero digits 3..1
//   for their whole slot; digit 0 is always shown.
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter logic [23:0] SCAN_DIV = 24'd10_000,
    parameter logic [7:0]  GUARD    = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        hold,
    output logic [3:0]  digit_en,
    output logic [3:0]  digit_val,
    output logic        frame_start
);

    logic [23:0] cnt;
    logic [1:0]  idx;
    logic [15:0] disp;
    logic [15:0] shadow;
    logic        pending;

    logic        slot_end;
    logic        frame_end;
    logic        in_guard;
    logic        blank_lead;

    // The last cycle of a slot, and the last cycle of the last slot of a
    // frame. A held cycle never counts as an end, so a frozen display can
    // never swap its contents while it sits still.
    always_comb begin
        slot_end  = (cnt == (SCAN_DIV - 24'd1));
        frame_end = !hold && (idx == 2'd3) && slot_end;
        in_guard  = (cnt < {16'd0, GUARD});
    end

    // Scan position: cnt walks through one slot, idx selects the digit and
    // wraps 3 -> 0 naturally through its 2-bit width. Hold simply stops both.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 24'd0;
            idx <= 2'd0;
        end else if (!hold) begin
            if (slot_end) begin
                cnt <= 24'd0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 24'd1;
            end
        end
    end

    // Write path: a value is parked in shadow and flagged pending, then moved
    // to disp at the end of a frame. The two branches can never both apply,
    // because a new value is only taken while nothing is pending; a value
    // accepted on the very boundary cycle therefore waits a full frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp    <= 16'd0;
            shadow  <= 16'd0;
            pending <= 1'b0;
        end else if (frame_end && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
        end else if (wr_valid && !pending) begin
            shadow  <= wr_data;
            pending <= 1'b1;
        end
    end

    // Leading-zero suppression: digit i is blanked when it and every digit
    // above it are zero. Digit 0 is never blanked so "0" still shows.
    always_comb begin
        blank_lead = 1'b0;
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
        case (idx)
            2'd1:    blank_lead = (disp[15:4]  == 12'd0);
            2'd2:    blank_lead = (disp[15:8]  == 8'd0);
            2'd3:    blank_lead = (disp[15:12] == 4'd0);
            default: blank_lead = 1'b0;
        endcase
`endif
    end

    // Output decode is purely combinational from the state registers. The
    // digit code is presented even during guard cycles so the decoder has
    // settled by the time the enable turns on; codes 10..15 pass through raw.
    always_comb begin
        wr_ready    = !pending;
        digit_val   = disp[{idx, 2'b00} +: 4];
        frame_start = (idx == 2'd0) && (cnt == 24'd0);
        if (in_guard || blank_lead) begin
            digit_en = 4'b0000;
        end else begin
            digit_en = 4'b0001 << idx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl with SCAN_DIV=8, GUARD=2
// (32-cycle frame). A behavioural model tracks the scan position as a plain
// count of non-held cycles since reset and derives every output from it; a
// compare process checks all outputs against the model each cycle. Directed
// phases add literal expectations at hand-picked cycles (cycle 0 is the
// first cycle after reset release).
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        hold;
    logic [3:0]  digit_en;
    logic [3:0]  digit_val;
    logic        frame_start;

    int checks;
    int errors;
    int cyc;

    int          pos;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_pend;
    logic        model_valid;

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    display_scan_ctrl #(
        .SCAN_DIV (24'd8),
        .GUARD    (8'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .hold        (hold),
        .digit_en    (digit_en),
        .digit_val   (digit_val),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its expectation and keeps the tally.
    task automatic checkOutput(input string name, input logic [3:0] act,
                               input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h",
                     name, cyc, act, exp);
        end
    endtask

    // Drives all DUT inputs at once, always from the falling edge.
    task automatic applyStimulus(input logic rst, input logic hld,
                                 input logic wv, input logic [15:0] wd);
        reset    = rst;
        hold     = hld;
        wr_valid = wv;
        wr_data  = wd;
    endtask

    // One reset edge; returns at the falling edge of cycle 0.
    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc = 0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    // Reference model: the display position is just the number of non-held
    // cycles since reset; a frame boundary is the last position of a frame.
    always @(posedge clk) begin
        if (reset) begin
            pos         = 0;
            m_disp      = 16'h0000;
            m_shadow    = 16'h0000;
            m_pend      = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (!hold && (pos % FRAME) == FRAME - 1 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (wr_valid && !m_pend) begin
                m_shadow = wr_data;
                m_pend   = 1'b1;
            end
            if (!hold) pos++;
        end
    end

    // Every cycle after the first reset, check all outputs against the model.
    always @(negedge clk) begin
        int          slot;
        logic [3:0]  e_en;
        logic [15:0] upper;
        if (model_valid) begin
            slot  = (pos / SD) % 4;
            upper = m_disp >> (4 * slot);
            if ((pos % SD) < GD) e_en = 4'b0000;
            else                 e_en = 4'(1 << slot);
            if (LZB && slot != 0 && upper == 16'h0000) e_en = 4'b0000;
            checkOutput("model_en", digit_en, e_en);
            checkOutput("model_val", digit_val, upper[3:0]);
            checkOutput("model_frame", {3'b0, frame_start},
                        {3'b0, (pos % FRAME) == 0});
            checkOutput("model_ready", {3'b0, wr_ready}, {3'b0, !m_pend});
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        model_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);

        // Phase A: reset release, write 1234, back-pressured write 5678.
        doReset();
        for (int c = 0; c <= 70; c++) begin
            case (c)
                0:  begin
                        checkOutput("a_frame0", {3'b0, frame_start}, 4'd1);
                        checkOutput("a_en0", digit_en, 4'b0000);
                    end
                1:  checkOutput("a_en1", digit_en, 4'b0000);
                2:  begin
                        checkOutput("a_en2", digit_en, 4'b0001);
                        checkOutput("a_val2", digit_val, 4'h0);
                    end
                6:  checkOutput("a_ready6", {3'b0, wr_ready}, 4'd0);
                10: checkOutput("a_en10", digit_en, 4'b0010);
                16: checkOutput("a_frame16", {3'b0, frame_start}, 4'd0);
                31: checkOutput("a_ready31", {3'b0, wr_ready}, 4'd0);
                32: begin
                        checkOutput("a_frame32", {3'b0, frame_start}, 4'd1);
                        checkOutput("a_ready32", {3'b0, wr_ready}, 4'd1);
                    end
                33: checkOutput("a_ready33", {3'b0, wr_ready}, 4'd0);
                34: begin
                        checkOutput("a_val34", digit_val, 4'h4);
                        checkOutput("a_en34", digit_en, 4'b0001);
                    end
                58: begin
                        checkOutput("a_val58", digit_val, 4'h1);
                        checkOutput("a_en58", digit_en, 4'b1000);
                    end
                63: checkOutput("a_val63", digit_val, 4'h1);
                64: begin
                        checkOutput("a_val64", digit_val, 4'h8);
                        checkOutput("a_en64", digit_en, 4'b0000);
                    end
                66: checkOutput("a_en66", digit_en, 4'b0001);
                default: ;
            endcase
            applyStimulus(1'b0, 1'b0, (c == 5) || (c >= 8 && c <= 32),
                          (c == 5) ? 16'h1234 : 16'h5678);
            nextCycle();
        end

        // Phase B: hold freezes slot 2, then reset while a write is pending.
        doReset();
        for (int c = 0; c <= 40; c++) begin
            case (c)
                20: checkOutput("b_en20", digit_en, 4'b0100);
                25: checkOutput("b_en25", digit_en, 4'b0100);
                30: checkOutput("b_en30", digit_en, 4'b0100);
                40: begin
                        checkOutput("b_ready40", {3'b0, wr_ready}, 4'd0);
                        checkOutput("b_en40", digit_en, 4'b1000);
                    end
                default: ;
            endcase
            if (c < 40) begin
                applyStimulus(1'b0, (c >= 20 && c <= 29), (c == 5), 16'h1234);
                nextCycle();
            end
        end
        doReset();
        checkOutput("b_rst_en", digit_en, 4'b0000);
        checkOutput("b_rst_val", digit_val, 4'h0);
        checkOutput("b_rst_frame", {3'b0, frame_start}, 4'd1);
        checkOutput("b_rst_ready", {3'b0, wr_ready}, 4'd1);

        // Phase C: leading-zero value 0050.
        for (int c = 0; c <= 63; c++) begin
            case (c)
                34: begin
                        checkOutput("c_val34", digit_val, 4'h0);
                        checkOutput("c_en34", digit_en, 4'b0001);
                    end
                42: begin
                        checkOutput("c_val42", digit_val, 4'h5);
                        checkOutput("c_en42", digit_en, 4'b0010);
                    end
                50: checkOutput("c_en50", digit_en, LZB ? 4'b0000 : 4'b0100);
                58: begin
                        checkOutput("c_val58", digit_val, 4'h0);
                        checkOutput("c_en58", digit_en,
                                    LZB ? 4'b0000 : 4'b1000);
                    end
                default: ;
            endcase
            applyStimulus(1'b0, 1'b0, (c == 5), 16'h0050);
            nextCycle();
        end

        // Phase D: write accepted exactly on the frame boundary cycle.
        doReset();
        for (int c = 0; c <= 75; c++) begin
            case (c)
                31: checkOutput("d_ready31", {3'b0, wr_ready}, 4'd1);
                32: begin
                        checkOutput("d_ready32", {3'b0, wr_ready}, 4'd0);
                        checkOutput("d_val32", digit_val, 4'h0);
                    end
                63: checkOutput("d_ready63", {3'b0, wr_ready}, 4'd0);
                64: begin
                        checkOutput("d_ready64", {3'b0, wr_ready}, 4'd1);
                        checkOutput("d_val64", digit_val, 4'hD);
                        checkOutput("d_frame64", {3'b0, frame_start}, 4'd1);
                    end
                66: checkOutput("d_en66", digit_en, 4'b0001);
                74: checkOutput("d_val74", digit_val, 4'hC);
                default: ;
            endcase
            applyStimulus(1'b0, 1'b0, (c == 31), 16'hABCD);
            nextCycle();
        end

        // Phase E: hold at the frame start keeps frame_start high.
        doReset();
        for (int c = 0; c <= 6; c++) begin
            case (c)
                3:  begin
                        checkOutput("e_frame3", {3'b0, frame_start}, 4'd1);
                        checkOutput("e_en3", digit_en, 4'b0000);
                    end
                4:  checkOutput("e_frame4", {3'b0, frame_start}, 4'd0);
                6:  checkOutput("e_en6", digit_en, 4'b0001);
                default: ;
            endcase
            applyStimulus(1'b0, (c <= 2), 1'b0, 16'h0000);
            nextCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
